axi4_arw_bram_responder: RTL and testbench
==========================================

Name: axi4_arw_bram_responder

Overview:
- AXI4 responder (slave) for the shared-address-channel protocol produced by AXI4_AWARMux: one combined ARW request channel, plus W, B and R channels.
- Backed by on-chip block RAM.
- Drop-in stand-in for the hbram controller, so axi4_ctrl and the AW/AR mux can be exercised in simulation and on boards without HyperRAM calibration.
- Serves exactly one burst at a time; INCR bursts only.

Parameters:
- AID_LEN, 4, width of the ID fields.
- AADDR_LEN, 32, byte-address width.
- DATA_WIDTH, 128, data bus width in bits (power of two, ≥ 16).
- MEM_DEPTH_LOG2, 10, log2 of the number of DATA_WIDTH-bit words.

Ports:
- aclk_i  in  1  sole clock.
- arst_i  in  1  synchronous, active-high reset.
- aid_i  in  AID_LEN  request ID.
- aaddr_i  in  AADDR_LEN  byte start address.
- alen_i  in  8  beats minus 1.
- atype_i  in  1  0 = read, 1 = write.
- avalid_i  in  1  request valid.
- aready_o  out  1  request ready.
- wid_i  in  AID_LEN  ignored.
- wdata_i  in  DATA_WIDTH  write data.
- wstrb_i  in  DATA_WIDTH/8  byte enables.
- wlast_i  in  1  last write beat.
- wvalid_i  in  1  write valid.
- wready_o  out  1  write ready.
- bid_o  out  AID_LEN  response ID.
- bresp_o  out  2  write response.
- bvalid_o  out  1  response valid.
- bready_i  in  1  response ready.
- rid_o  out  AID_LEN  read ID.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response.
- rlast_o  out  1  last read beat.
- rvalid_o  out  1  read valid.
- rready_i  in  1  read ready.

Behaviour:
- All outputs are registered. During any cycle with arst_i = 1, every output is 0.
- After reset, state = IDLE and aready_o = 1 from the first cycle after arst_i falls.
- Reset mid-burst: abandons the burst at the next edge (no B or R completion) and returns to IDLE. Memory contents are retained, never cleared.
- Word index = aaddr_i[ALSB+MEM_DEPTH_LOG2-1 : ALSB], where ALSB = log2(DATA_WIDTH/8).
  - Lower address bits are ignored.
  - Upper bits alias, unless the optional feature is enabled.
  - The index increments by 1 per beat and wraps modulo 2^MEM_DEPTH_LOG2.
- State machine: IDLE, WRITE, WRESP, RD_FETCH, RD_DATA.
- IDLE:
  - aready_o = 1.
  - On avalid_i & aready_o: latch id, index, len; clear beat counter; deassert aready_o.
  - Next state: WRITE if atype_i = 1, else RD_FETCH.
- WRITE:
  - wready_o = 1.
  - Each wvalid_i & wready_o writes the bytes selected by wstrb_i at the current index, then index++ and cnt++.
  - wstrb = 0 leaves the word unchanged.
  - On an accepted beat with wlast_i: wready_o drops next cycle, bvalid_o = 1, state WRESP.
  - bresp_o = 2'b00 if cnt == len on the wlast beat, else 2'b10 (SLVERR). Extra or missing beats are still written.
- WRESP:
  - Hold bvalid_o, bid_o and bresp_o stable until bready_i, then go to IDLE.
  - aready_o returns high the cycle after the B handshake.
- RD_FETCH:
  - Synchronous RAM read of the current index (one cycle).
  - Next cycle: state RD_DATA, rvalid_o = 1, rdata_o = word, rid_o = id, rresp_o = 00, rlast_o = (cnt == len).
- RD_DATA:
  - Hold rvalid_o and R payload stable until rready_i.
  - On handshake: if rlast_o, go to IDLE; else index++, cnt++, go to RD_FETCH.
  - Throughput is one beat per 2 cycles minimum; rvalid_o is 0 in RD_FETCH.
- Read-after-write: a read accepted after the B handshake returns the written data.
- No outstanding transactions: a new request is accepted only in IDLE.
- alen_i = 255 is legal (256 beats).

Optional Feature:
- Macro: RESP_RANGE_CHECK_EN.
- Defined: any burst whose start byte address ≥ 2^(MEM_DEPTH_LOG2+ALSB) is flagged out of range.
  - Out-of-range write: consumes all W beats without writing; bresp_o = 2'b11 (DECERR).
  - Out-of-range read: returns len+1 beats of rdata_o = 0 with rresp_o = 2'b11; rlast_o as normal.
  - A burst that starts in range and crosses the top wraps as normal.
- Undefined: upper address bits alias; responses are never DECERR.

Decomposition:
- Shared package axi4_resp_pkg:
  - Response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - State enum encoding.
  - ALSB derivation function.
- One sub-module: bram_be_sp.
  - Single-port RAM, byte-enable write, 1-cycle registered read, no reset.
  - Instantiated once.
- The top holds the FSM, counters and channel registers.

Test Plan:
- Write then read: id 3, addr 0x40, len 3, data 0x11..0x44 with full strobe, then read addr 0x40 len 3 → B id 3 resp 00; R 4 beats 0x11, 0x22, 0x33, 0x44, rlast on 4th only, rid 3.
- Byte strobe: write 0xFFFF_FFFF… with wstrb 0x0001 over a word preloaded with 0 → subsequent read returns 0x…00FF.
- Short burst: len 3 write with wlast on beat 2 → bresp 2'b10; words 0..2 written, word 3 unchanged; next request accepted.
- Backpressure: rready low for 5 cycles on beat 1 and bready low for 3 cycles → payload stable throughout; aready_o low until the final handshake.
- Wrap and reset: write len 1 at word 1023 → beats at words 1023 and 0. Assert arst_i mid 8-beat read → rvalid 0 next cycle; aready 1 one cycle after release; previously written data intact.
- With RESP_RANGE_CHECK_EN: read addr 0x4000 len 1 → two beats, rdata 0, rresp 11; write same → bresp 11, memory unchanged.

Source files
------------

// File: rtl/axi4_resp_pkg.sv
// Shared definitions for the ARW-channel BRAM responder.
//   RESP_*    : AXI response codes
//   state_e   : responder FSM encoding
//   calc_alsb : byte-offset width for a data bus of the given width
package axi4_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RD_FETCH,
    ST_RD_DATA
  } state_e;

  // Number of low address bits that select a byte within one data word.
  function automatic int calc_alsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_arw_bram_responder_bram.sv
// bram_be_sp: single-port RAM with per-byte write enables and a one-cycle
// registered read. No reset: contents and read register survive system reset.
//   clk_i   : clock
//   en_i    : access enable (read when we_i=0, write when we_i=1)
//   we_i    : write select
//   be_i    : byte enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access, held otherwise
module bram_be_sp #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DEPTH_LOG2-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  // One narrow array per byte lane keeps each lane a plain BRAM column.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [2**DEPTH_LOG2];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        if (we_i) begin
          if (be_i[l]) mem[addr_i] <= wdata_i[l*8 +: 8];
        end else begin
          rd_q <= mem[addr_i];
        end
      end
    end

    assign rdata_o[l*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/axi4_arw_bram_responder.sv
// axi4_arw_bram_responder: AXI4 responder for a shared AW/AR request channel,
// backed by block RAM. One INCR burst in flight at a time.
//   aclk_i/arst_i          : clock, synchronous active-high reset
//   aid/aaddr/alen/atype   : combined request channel (atype 1 = write)
//   w*                     : write data channel (wid_i ignored)
//   b*                     : write response channel
//   r*                     : read data channel
// All outputs come straight from flops.
// Build option RESP_RANGE_CHECK_EN: bursts starting beyond the RAM return
// DECERR (writes dropped, reads return zero) instead of aliasing.
module axi4_arw_bram_responder
  import axi4_resp_pkg::*;
#(
  parameter int AID_LEN        = 4,
  parameter int AADDR_LEN      = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    aclk_i,
  input  logic                    arst_i,
  input  logic [AID_LEN-1:0]      aid_i,
  input  logic [AADDR_LEN-1:0]    aaddr_i,
  input  logic [7:0]              alen_i,
  input  logic                    atype_i,
  input  logic                    avalid_i,
  output logic                    aready_o,
  input  logic [AID_LEN-1:0]      wid_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [AID_LEN-1:0]      bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [AID_LEN-1:0]      rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int ALSB  = calc_alsb(DATA_WIDTH);
  localparam int IDX_W = MEM_DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [AID_LEN-1:0]    id_q, id_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  // One extra bit so a 256-beat burst does not wrap back onto len.
  logic [8:0]            cnt_q, cnt_d;
  logic                  oor_q, oor_d;
  logic                  aready_q, aready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [AID_LEN-1:0]    bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [AID_LEN-1:0]    rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic                  ram_en, ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Low byte-offset bits and wid_i carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{wid_i, aaddr_i};

  bram_be_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (IDX_W)
  ) u_ram (
    .clk_i   (aclk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (wstrb_i),
    .addr_i  (ram_addr),
    .wdata_i (wdata_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    oor_d    = oor_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (avalid_i && aready_q) begin
          id_d  = aid_i;
          idx_d = aaddr_i[ALSB+IDX_W-1:ALSB];
          len_d = alen_i;
          cnt_d = '0;
`ifdef RESP_RANGE_CHECK_EN
          oor_d = |aaddr_i[AADDR_LEN-1:ALSB+IDX_W];
`else
          oor_d = 1'b0;
`endif
          if (atype_i) begin
            state_d = ST_WRITE;
          end else begin
            // Launch the RAM read now so the word is ready while in RD_FETCH.
            state_d  = ST_RD_FETCH;
            ram_en   = 1'b1;
            ram_addr = idx_d;
          end
        end
      end

      ST_WRITE: begin
        if (wvalid_i && wready_q) begin
          ram_en = !oor_q;
          ram_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (wlast_i) begin
            state_d = ST_WRESP;
            bid_d   = id_q;
            if (oor_q)                       bresp_d = RESP_DECERR;
            else if (cnt_q == {1'b0, len_q}) bresp_d = RESP_OKAY;
            else                             bresp_d = RESP_SLVERR;
          end
        end
      end

      ST_WRESP: begin
        if (bvalid_q && bready_i) state_d = ST_IDLE;
      end

      ST_RD_FETCH: begin
        state_d = ST_RD_DATA;
        rid_d   = id_q;
        rdata_d = oor_q ? '0 : ram_rdata;
        rresp_d = oor_q ? RESP_DECERR : RESP_OKAY;
        rlast_d = (cnt_q == {1'b0, len_q});
      end

      ST_RD_DATA: begin
        if (rvalid_q && rready_i) begin
          if (rlast_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            state_d  = ST_RD_FETCH;
            ram_en   = 1'b1;
            ram_addr = idx_d;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A beat arriving during reset must not touch memory.
    if (arst_i) ram_en = 1'b0;

    // Handshake flags follow the state being entered.
    aready_d = (state_d == ST_IDLE);
    wready_d = (state_d == ST_WRITE);
    bvalid_d = (state_d == ST_WRESP);
    rvalid_d = (state_d == ST_RD_DATA);
  end

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      oor_q    <= 1'b0;
      aready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      oor_q    <= oor_d;
      aready_q <= aready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  assign aready_o = aready_q;
  assign wready_o = wready_q;
  assign bvalid_o = bvalid_q;
  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;

endmodule

// File: tb/tb_axi4_arw_bram_responder.sv
// Scoreboard bench for axi4_arw_bram_responder (default parameters).
// Expected B/R results are queued from a byte-accurate memory model when a
// burst is issued and popped as the DUT responds.
module tb_axi4_arw_bram_responder;

  logic         aclk = 1'b0;
  logic         arst;
  logic [3:0]   aid;
  logic [31:0]  aaddr;
  logic [7:0]   alen;
  logic         atype, avalid, aready_o;
  logic [3:0]   wid;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready_o;
  logic [3:0]   bid_o;
  logic [1:0]   bresp_o;
  logic         bvalid_o, bready;
  logic [3:0]   rid_o;
  logic [127:0] rdata_o;
  logic [1:0]   rresp_o;
  logic         rlast_o, rvalid_o, rready;

  always #5 aclk = ~aclk;

  axi4_arw_bram_responder dut (
    .aclk_i(aclk), .arst_i(arst),
    .aid_i(aid), .aaddr_i(aaddr), .alen_i(alen), .atype_i(atype),
    .avalid_i(avalid), .aready_o(aready_o),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .wvalid_i(wvalid), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready)
  );

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t       rq[$];
  bexp_t        bq[$];
  logic [127:0] model [1024];
  logic [127:0] wbuf  [256];
  logic [15:0]  wstb  [256];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
`ifdef RESP_RANGE_CHECK_EN
    return a >= 32'h4000;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_req(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic typ);
    int n = 0;
    aid = id; aaddr = addr; alen = len; atype = typ; avalid = 1'b1;
    while (!aready_o && n < 200) begin tick(); n++; end
    if (!aready_o) chk("req_timeout", aready_o, 1);
    tick();
    avalid = 1'b0;
    chk("aready_drop", aready_o, 0);
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int nbeats, input int bdelay);
    logic [9:0] idx = addr[13:4];
    bit         o   = oor(addr);
    bexp_t      e;
    int         n;
    e.id   = id;
    e.resp = o ? 2'b11 : ((nbeats == int'(len) + 1) ? 2'b00 : 2'b10);
    bq.push_back(e);
    send_req(id, addr, len, 1'b1);
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = wstb[b];
      wlast = (b == nbeats - 1); wid = ~id;
      n = 0;
      while (!wready_o && n < 50) begin tick(); n++; end
      if (!wready_o) chk("wready_timeout", wready_o, 1);
      tick();
      if (!o)
        for (int k = 0; k < 16; k++)
          if (wstb[b][k]) model[idx][k*8 +: 8] = wbuf[b][k*8 +: 8];
      idx++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wready_drop", wready_o, 0);
    n = 0;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    e = bq.pop_front();
    chk("bvalid", bvalid_o, 1);
    chk("bid", bid_o, e.id);
    chk("bresp", bresp_o, e.resp);
    for (int d = 0; d < bdelay; d++) begin
      tick();
      chk("b_hold", {bvalid_o, bid_o, bresp_o}, {1'b1, e.id, e.resp});
      chk("aready_busy_b", aready_o, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clear", bvalid_o, 0);
    chk("aready_after_b", aready_o, 1);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int stall_beat, input int stall_cyc);
    logic [9:0] idx = addr[13:4];
    bit         o   = oor(addr);
    rbeat_t     e;
    int         n;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.data = o ? 128'h0 : model[idx];
      e.resp = o ? 2'b11 : 2'b00;
      e.last = (b == int'(len));
      rq.push_back(e);
      idx++;
    end
    send_req(id, addr, len, 1'b0);
    chk("rvalid_fetch", rvalid_o, 0);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid_o && n < 50) begin tick(); n++; end
      chk("rvalid", rvalid_o, 1);
      e = rq.pop_front();
      chk("rid", rid_o, e.id);
      chk("rdata", rdata_o, e.data);
      chk("rresp", rresp_o, e.resp);
      chk("rlast", rlast_o, e.last);
      if (b == stall_beat)
        for (int s = 0; s < stall_cyc; s++) begin
          tick();
          chk("r_hold", {rvalid_o, rid_o, rresp_o, rlast_o, rdata_o},
                        {1'b1, e.id, e.resp, e.last, e.data});
          chk("aready_busy_r", aready_o, 0);
        end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_gap", rvalid_o, 0);
    end
    chk("aready_after_r", aready_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    arst = 1'b1; aid = '0; aaddr = '0; alen = '0; atype = 1'b0; avalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_outs", {aready_o, wready_o, bvalid_o, rvalid_o, rlast_o, bresp_o, rresp_o, bid_o, rid_o},
                    '0);
    chk("rst_rdata", rdata_o, 0);
    arst = 1'b0;
    tick();
    chk("aready_post_rst", aready_o, 1);

    // Write then read, 4 beats
    wbuf[0] = 128'h11; wbuf[1] = 128'h22; wbuf[2] = 128'h33; wbuf[3] = 128'h44;
    for (int b = 0; b < 4; b++) wstb[b] = 16'hFFFF;
    wr_burst(4'd3, 32'h40, 8'd3, 4, 0);
    rd_burst(4'd3, 32'h40, 8'd3, -1, 0);

    // Byte strobe over a zeroed word
    wbuf[0] = '0; wstb[0] = 16'hFFFF;
    wr_burst(4'd1, 32'h100, 8'd0, 1, 0);
    wbuf[0] = '1; wstb[0] = 16'h0001;
    wr_burst(4'd1, 32'h100, 8'd0, 1, 0);
    wstb[0] = 16'h0000;
    wr_burst(4'd1, 32'h100, 8'd0, 1, 0);
    rd_burst(4'd1, 32'h100, 8'd0, -1, 0);

    // Short burst: 3 beats for len 3, fourth word untouched
    for (int b = 0; b < 4; b++) begin wbuf[b] = 128'hA0 + 128'(b); wstb[b] = 16'hFFFF; end
    wr_burst(4'd4, 32'h200, 8'd3, 4, 0);
    for (int b = 0; b < 4; b++) wbuf[b] = 128'hB0 + 128'(b);
    wr_burst(4'd4, 32'h200, 8'd3, 3, 0);
    rd_burst(4'd4, 32'h200, 8'd3, -1, 0);

    // Extra beat: len 0 with 2 beats, both written
    wbuf[0] = 128'hC0; wbuf[1] = 128'hC1;
    wr_burst(4'd2, 32'h800, 8'd0, 2, 0);
    rd_burst(4'd2, 32'h800, 8'd1, -1, 0);

    // Backpressure on R beat 1 and on B
    rd_burst(4'd3, 32'h40, 8'd3, 1, 5);
    wbuf[0] = 128'hD00D; wstb[0] = 16'hFFFF;
    wr_burst(4'd6, 32'h300, 8'd0, 1, 3);

    // Wrap at the top word
    wbuf[0] = 128'hE1; wbuf[1] = 128'hE2; wstb[0] = 16'hFFFF; wstb[1] = 16'hFFFF;
    wr_burst(4'd7, 32'h3FF0, 8'd1, 2, 0);
    rd_burst(4'd7, 32'h3FF0, 8'd1, -1, 0);
    rd_burst(4'd7, 32'h0, 8'd0, -1, 0);

    // Reset in the middle of an 8-beat read
    send_req(4'd5, 32'h40, 8'd7, 1'b0);
    tick();
    chk("mid_rdata0", rdata_o, model[4]);
    rready = 1'b1; tick(); rready = 1'b0;
    tick();
    chk("mid_rvalid1", rvalid_o, 1);
    arst = 1'b1;
    tick();
    chk("mid_rst_rvalid", rvalid_o, 0);
    chk("mid_rst_aready", aready_o, 0);
    arst = 1'b0;
    tick();
    chk("mid_rst_release", aready_o, 1);
    rd_burst(4'd3, 32'h40, 8'd3, -1, 0);

    // Start address above the RAM: DECERR with the range check, alias without
    rd_burst(4'd9, 32'h4000, 8'd1, -1, 0);
    wbuf[0] = 128'hF0; wbuf[1] = 128'hF1;
    wr_burst(4'd9, 32'h4000, 8'd1, 2, 0);
    rd_burst(4'd9, 32'h0, 8'd1, -1, 0);

    // Random full-strobe bursts
    for (int t = 0; t < 4; t++) begin
      logic [31:0] a;
      logic [7:0]  l;
      a = 32'($urandom_range(0, 1023)) << 4;
      l = 8'($urandom_range(0, 7));
      for (int b = 0; b <= int'(l); b++) begin
        wbuf[b] = {$urandom, $urandom, $urandom, $urandom};
        wstb[b] = 16'hFFFF;
      end
      wr_burst(4'(t), a, l, int'(l) + 1, t);
      rd_burst(4'(t), a, l, t % 2, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
